lc_arbiter: RTL and testbench
=============================

Name: lc_arbiter

Overview:
- Lower-cache arbiter below the core. It merges L1I line-fill reads and L1D fill/write-back traffic onto one 512-bit memory/L2 port.
- Routes in-order memory read responses back to the requesting L1 on that L1's lc response channel.
- Feeds the core's l1i_lc_* and l1d_lc_* input ports.
- Round-robin arbitration, a single-entry issue register, and an outstanding-read ID FIFO.

Parameters:
- ADDR_W, 64, request/response address width.
- LINE_W, 512, cache line width in bits.
- MAX_OUTSTANDING, 4, maximum reads issued to memory and not yet answered (power of 2, ≥2).

Ports:
- clk_in  in  1  clock
- rst_N_in  in  1  synchronous active-low reset
- cs_N_in  in  1  chip select, active-low; when high, no new grants are made
- l1i_req_valid_in  in  1  L1I read request valid
- l1i_req_addr_in  in  ADDR_W  L1I line address
- l1i_req_ready_out  out  1  L1I request accepted this cycle
- l1d_req_valid_in  in  1  L1D request valid
- l1d_req_addr_in  in  ADDR_W  L1D line address
- l1d_req_value_in  in  LINE_W  L1D write-back data
- l1d_req_we_in  in  1  L1D write (1) / read (0)
- l1d_req_ready_out  out  1  L1D request accepted this cycle
- l1i_resp_valid_out  out  1  line fill to L1I valid
- l1i_resp_ready_in  in  1  L1I can accept fill
- l1d_resp_valid_out  out  1  line fill to L1D valid
- l1d_resp_ready_in  in  1  L1D can accept fill
- resp_addr_out  out  ADDR_W  fill address (shared by both clients)
- resp_value_out  out  LINE_W  fill data (shared by both clients)
- mem_valid_out  out  1  request to memory valid
- mem_ready_in  in  1  memory accepts request
- mem_addr_out  out  ADDR_W  request address
- mem_value_out  out  LINE_W  write data
- mem_we_out  out  1  write enable
- mem_valid_in  in  1  memory read response valid
- mem_ready_out  out  1  arbiter accepts response
- mem_addr_in  in  ADDR_W  response address
- mem_value_in  in  LINE_W  response data

Behaviour:
- Reset (rst_N_in=0 at posedge):
  - Issue register empty; ID FIFO empty; rr pointer = L1I.
  - All valid/ready outputs are 0; data/address outputs are 0.
- Reset mid-operation discards the held request and all outstanding IDs. Later memory responses are handled by the orphan rule.
- Issue FSM has two states:
  - IDLE: issue register empty.
  - HOLD: mem_valid_out=1, holding address, value and we registered at grant.
  - HOLD→IDLE on mem_ready_in=1.
  - Grant and HOLD exit cannot occur in the same cycle. A grant is possible only in IDLE, so the maximum issue rate is one request per 2 cycles.
- Grant conditions, IDLE only:
  - cs_N_in=0.
  - For a read: ID FIFO not full, counting a same-cycle pop as freeing a slot.
- Arbitration:
  - Both eligible: grant the client not granted last; the rr pointer updates on each grant.
  - One eligible: grant it.
  - Reads from L1I are always we=0.
- req_ready_out is combinational and is asserted only for the granted client. A grant captures the request into the issue register; the next cycle is HOLD.
- Read grant pushes the client ID into the FIFO at grant time. Writes push nothing and are complete once memory accepts them.
- Response routing (combinational):
  - When the FIFO is non-empty, the head ID selects the client.
  - That client's resp_valid_out = mem_valid_in.
  - resp_addr_out/resp_value_out = mem_addr_in/mem_value_in.
  - mem_ready_out = the selected client's resp_ready_in.
  - The other client's resp_valid_out = 0.
  - FIFO pops on mem_valid_in & mem_ready_out.
- Orphan response (mem_valid_in=1, FIFO empty): mem_ready_out=1; the response is consumed and dropped; no resp_valid_out is raised.
- Simultaneous push and pop: both take effect; count is unchanged. Push when full and popping is allowed.
- Memory responses must be in request order; the arbiter does not check addresses.
- cs_N_in high does not stall an in-flight HOLD or response routing.

Optional Feature:
- Macro LC_ARBITER_PERF_EN.
- Defined:
  - Adds 32-bit saturating outputs perf_l1i_grants_out, perf_l1d_grants_out and perf_stall_cycles_out.
  - perf_stall_cycles_out counts cycles where some req_valid=1 but no grant was made.
  - Adds a 1-bit sticky output perf_orphan_out, set on any orphan response.
  - All four clear on reset.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package lc_pkg holds:
  - client-ID enum lc_client_e {LC_L1I=0, LC_L1D=1}.
  - struct lc_req_t {addr, value, we}.
  - constants LC_LINE_W=512 and LC_ADDR_W=64.
- Sub-module lc_id_fifo:
  - Parameterised depth, 1-bit entries, synchronous active-low reset.
  - Ports for push, pop, head, full and empty; a pop when empty is ignored.

Test Plan:
- L1I read 0x1000 alone, mem_ready_in=1 → l1i_req_ready_out pulses 1 cycle; mem_valid_out next cycle with addr 0x1000, we=0; memory returns 0xAA…AA → l1i_resp_valid_out=1 with that value; l1d_resp_valid_out stays 0.
- Both clients valid continuously (L1I 0x40, L1D 0x80 read), rr starting at L1I → grants alternate L1D, L1I, L1D… (the first grant goes to L1D because rr=L1I after reset); responses route strictly in grant order.
- L1D write 0x2000, data 0x55…55 → mem_we_out=1, no FIFO push; a later response with the FIFO empty is dropped with mem_ready_out=1.
- Issue 4 reads with no responses (MAX_OUTSTANDING=4) → 5th read not granted; one response popped → 5th granted the same cycle.
- mem_valid_in=1 for an L1D response with l1d_resp_ready_in=0 for 3 cycles → mem_ready_out=0, FIFO head held; ready rises → pop.
- Assert rst_N_in while in HOLD with 2 reads outstanding → all outputs 0 next cycle; the next memory response is treated as an orphan.

Source files
------------

// File: rtl/lc_pkg.sv
// Shared types for the lower-cache arbiter.
// Client IDs, request bundle, issue FSM states and widths.
package lc_pkg;

  localparam int unsigned LC_LINE_W = 512;
  localparam int unsigned LC_ADDR_W = 64;

  typedef enum logic {
    LC_L1I = 1'b0,
    LC_L1D = 1'b1
  } lc_client_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } lc_state_e;

  typedef struct packed {
    logic [LC_ADDR_W-1:0] addr;
    logic [LC_LINE_W-1:0] value;
    logic                 we;
  } lc_req_t;

endpackage

// File: rtl/lc_id_fifo.sv
// Outstanding-read client-ID FIFO, 1-bit entries.
// A pop when empty is ignored; push while full needs a same-cycle pop.
module lc_id_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_in,
  input  logic rst_N_in,
  input  logic push_in,
  input  logic push_id_in,
  input  logic pop_in,
  output logic head_out,
  output logic full_out,
  output logic empty_out
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic             w_pop;
  logic             w_push;

  assign empty_out = (r_cnt == '0);
  assign full_out  = (r_cnt == (AW+1)'(DEPTH));
  assign head_out  = r_mem[r_rp];
  assign w_pop     = pop_in & ~empty_out;
  assign w_push    = push_in & (~full_out | w_pop);

  // Pointer, count and storage update.
  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      r_mem <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= push_id_in;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_pop && !w_push) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/lc_arbiter.sv
// Round-robin L1I/L1D arbiter onto one line-wide memory port.
// Optional counters under LC_ARBITER_PERF_EN.
module lc_arbiter
  import lc_pkg::*;
#(
  parameter int unsigned ADDR_W          = LC_ADDR_W,
  parameter int unsigned LINE_W          = LC_LINE_W,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic              clk_in,
  input  logic              rst_N_in,
  input  logic              cs_N_in,
  input  logic              l1i_req_valid_in,
  input  logic [ADDR_W-1:0] l1i_req_addr_in,
  output logic              l1i_req_ready_out,
  input  logic              l1d_req_valid_in,
  input  logic [ADDR_W-1:0] l1d_req_addr_in,
  input  logic [LINE_W-1:0] l1d_req_value_in,
  input  logic              l1d_req_we_in,
  output logic              l1d_req_ready_out,
  output logic              l1i_resp_valid_out,
  input  logic              l1i_resp_ready_in,
  output logic              l1d_resp_valid_out,
  input  logic              l1d_resp_ready_in,
  output logic [ADDR_W-1:0] resp_addr_out,
  output logic [LINE_W-1:0] resp_value_out,
  output logic              mem_valid_out,
  input  logic              mem_ready_in,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [LINE_W-1:0] mem_value_out,
  output logic              mem_we_out,
  input  logic              mem_valid_in,
  output logic              mem_ready_out,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [LINE_W-1:0] mem_value_in
`ifdef LC_ARBITER_PERF_EN
  ,
  output logic [31:0]       perf_l1i_grants_out,
  output logic [31:0]       perf_l1d_grants_out,
  output logic [31:0]       perf_stall_cycles_out,
  output logic              perf_orphan_out
`endif
);

  lc_state_e  r_state;
  lc_client_e r_rr;
  lc_req_t    r_req;

  logic w_head;
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_rd_space;
  logic w_can;
  logic w_i_elig;
  logic w_d_elig;
  logic w_gnt_i;
  logic w_gnt_d;
  logic w_orphan;

  // Response routing by the oldest outstanding read's client ID.
  always_comb begin
    l1i_resp_valid_out = 1'b0;
    l1d_resp_valid_out = 1'b0;
    mem_ready_out      = 1'b0;
    if (w_empty) begin
      mem_ready_out = mem_valid_in;
    end else if (w_head == LC_L1D) begin
      l1d_resp_valid_out = mem_valid_in;
      mem_ready_out      = l1d_resp_ready_in;
    end else begin
      l1i_resp_valid_out = mem_valid_in;
      mem_ready_out      = l1i_resp_ready_in;
    end
  end

  assign resp_addr_out  = mem_addr_in;
  assign resp_value_out = mem_value_in;
  assign w_pop    = mem_valid_in & mem_ready_out & ~w_empty;
  assign w_orphan = mem_valid_in & w_empty;

  // Grant eligibility and round-robin choice.
  always_comb begin
    w_rd_space = ~w_full | w_pop;
    w_can      = rst_N_in & ~cs_N_in & (r_state == ST_IDLE);
    w_i_elig   = w_can & l1i_req_valid_in & w_rd_space;
    w_d_elig   = w_can & l1d_req_valid_in
               & (l1d_req_we_in | w_rd_space);
    w_gnt_d    = w_d_elig & (~w_i_elig | (r_rr == LC_L1I));
    w_gnt_i    = w_i_elig & ~w_gnt_d;
    w_push     = w_gnt_i | (w_gnt_d & ~l1d_req_we_in);
  end

  assign l1i_req_ready_out = w_gnt_i;
  assign l1d_req_ready_out = w_gnt_d;

  assign mem_valid_out = (r_state == ST_HOLD);
  assign mem_addr_out  = r_req.addr;
  assign mem_value_out = r_req.value;
  assign mem_we_out    = r_req.we;

  lc_id_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_in    (clk_in),
    .rst_N_in  (rst_N_in),
    .push_in   (w_push),
    .push_id_in(w_gnt_d),
    .pop_in    (w_pop),
    .head_out  (w_head),
    .full_out  (w_full),
    .empty_out (w_empty)
  );

  // Issue FSM: capture on grant, hold until memory accepts.
  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      r_state <= ST_IDLE;
      r_rr    <= LC_L1I;
      r_req   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_gnt_d) begin
            r_req.addr  <= l1d_req_addr_in;
            r_req.value <= l1d_req_value_in;
            r_req.we    <= l1d_req_we_in;
            r_rr        <= LC_L1D;
            r_state     <= ST_HOLD;
          end else if (w_gnt_i) begin
            r_req.addr  <= l1i_req_addr_in;
            r_req.value <= '0;
            r_req.we    <= 1'b0;
            r_rr        <= LC_L1I;
            r_state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (mem_ready_in) begin
            r_req   <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef LC_ARBITER_PERF_EN
  logic [31:0] r_perf_i;
  logic [31:0] r_perf_d;
  logic [31:0] r_perf_stall;
  logic        r_perf_orphan;
  logic        w_any_req;

  assign w_any_req = l1i_req_valid_in | l1d_req_valid_in;

  // Saturating grant/stall counters and sticky orphan flag.
  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      r_perf_i      <= '0;
      r_perf_d      <= '0;
      r_perf_stall  <= '0;
      r_perf_orphan <= 1'b0;
    end else begin
      if (w_gnt_i && r_perf_i != '1) begin
        r_perf_i <= r_perf_i + 1'b1;
      end
      if (w_gnt_d && r_perf_d != '1) begin
        r_perf_d <= r_perf_d + 1'b1;
      end
      if (w_any_req && !w_gnt_i && !w_gnt_d
          && r_perf_stall != '1) begin
        r_perf_stall <= r_perf_stall + 1'b1;
      end
      if (w_orphan) begin
        r_perf_orphan <= 1'b1;
      end
    end
  end

  assign perf_l1i_grants_out   = r_perf_i;
  assign perf_l1d_grants_out   = r_perf_d;
  assign perf_stall_cycles_out = r_perf_stall;
  assign perf_orphan_out       = r_perf_orphan;
`else
  logic w_unused;
  assign w_unused = w_orphan;
`endif

endmodule

// File: tb/tb_lc_arbiter.sv
// Directed self-checking bench for lc_arbiter.
// Default build (LC_ARBITER_PERF_EN undefined).
module tb_lc_arbiter;
  import lc_pkg::*;

  localparam int AW = 64;
  localparam int LW = 512;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cs_n;
  logic          i_vld;
  logic [AW-1:0] i_addr;
  logic          i_rdy;
  logic          d_vld;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_val;
  logic          d_we;
  logic          d_rdy;
  logic          i_rv;
  logic          i_rr;
  logic          d_rv;
  logic          d_rr;
  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_val;
  logic          m_vo;
  logic          m_ri;
  logic [AW-1:0] m_ao;
  logic [LW-1:0] m_do;
  logic          m_we;
  logic          m_vi;
  logic          m_ro;
  logic [AW-1:0] m_ai;
  logic [LW-1:0] m_di;

  int n_tests = 0;
  int n_fail  = 0;

  logic [LW-1:0] pat_a;
  logic [LW-1:0] pat_5;

  always #5 clk = ~clk;

  lc_arbiter dut (
    .clk_in            (clk),
    .rst_N_in          (rst_n),
    .cs_N_in           (cs_n),
    .l1i_req_valid_in  (i_vld),
    .l1i_req_addr_in   (i_addr),
    .l1i_req_ready_out (i_rdy),
    .l1d_req_valid_in  (d_vld),
    .l1d_req_addr_in   (d_addr),
    .l1d_req_value_in  (d_val),
    .l1d_req_we_in     (d_we),
    .l1d_req_ready_out (d_rdy),
    .l1i_resp_valid_out(i_rv),
    .l1i_resp_ready_in (i_rr),
    .l1d_resp_valid_out(d_rv),
    .l1d_resp_ready_in (d_rr),
    .resp_addr_out     (r_addr),
    .resp_value_out    (r_val),
    .mem_valid_out     (m_vo),
    .mem_ready_in      (m_ri),
    .mem_addr_out      (m_ao),
    .mem_value_out     (m_do),
    .mem_we_out        (m_we),
    .mem_valid_in      (m_vi),
    .mem_ready_out     (m_ro),
    .mem_addr_in       (m_ai),
    .mem_value_in      (m_di)
  );

  task automatic chk(input string tag,
                     input logic [LW-1:0] obs,
                     input logic [LW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  task automatic pedge();
    @(posedge clk);
  endtask

  initial begin
    pat_a  = {64{8'hAA}};
    pat_5  = {64{8'h55}};
    rst_n  = 1'b0;
    cs_n   = 1'b0;
    i_vld  = 1'b0;
    i_addr = '0;
    d_vld  = 1'b0;
    d_addr = '0;
    d_val  = '0;
    d_we   = 1'b0;
    i_rr   = 1'b1;
    d_rr   = 1'b1;
    m_ri   = 1'b1;
    m_vi   = 1'b0;
    m_ai   = '0;
    m_di   = '0;

    // reset state
    pedge(); pedge();
    nedge(); #1;
    chk("rst_mem_valid", m_vo, 0);
    chk("rst_mem_addr", m_ao, 0);
    chk("rst_mem_we", m_we, 0);
    chk("rst_i_rdy", i_rdy, 0);
    chk("rst_d_rdy", d_rdy, 0);
    chk("rst_i_rv", i_rv, 0);
    chk("rst_d_rv", d_rv, 0);
    chk("rst_mem_ro", m_ro, 0);
    rst_n = 1'b1;

    // cs_N high blocks grant
    nedge();
    cs_n = 1'b1; i_vld = 1'b1; i_addr = 64'h1000;
    #1 chk("cs_block", i_rdy, 0);
    cs_n = 1'b0;

    // single L1I read
    #1 chk("t1_i_rdy", i_rdy, 1);
    chk("t1_d_rdy", d_rdy, 0);
    pedge();
    nedge(); i_vld = 1'b0;
    #1 chk("t1_mem_vo", m_vo, 1);
    chk("t1_mem_ao", m_ao, 64'h1000);
    chk("t1_mem_we", m_we, 0);
    chk("t1_hold_no_rdy", i_rdy, 0);
    pedge();
    nedge(); #1 chk("t1_idle", m_vo, 0);
    m_vi = 1'b1; m_ai = 64'h1000; m_di = pat_a;
    #1 chk("t1_i_rv", i_rv, 1);
    chk("t1_d_rv", d_rv, 0);
    chk("t1_r_val", r_val, pat_a);
    chk("t1_r_addr", r_addr, 64'h1000);
    chk("t1_m_ro", m_ro, 1);
    pedge();
    nedge(); m_vi = 1'b0;

    // both valid: rr alternates D, I, D
    i_vld = 1'b1; i_addr = 64'h40;
    d_vld = 1'b1; d_addr = 64'h80; d_we = 1'b0;
    #1 chk("t2_g1_d", d_rdy, 1);
    chk("t2_g1_i", i_rdy, 0);
    pedge();
    nedge(); #1 chk("t2_g1_addr", m_ao, 64'h80);
    pedge();
    nedge(); #1 chk("t2_g2_i", i_rdy, 1);
    chk("t2_g2_d", d_rdy, 0);
    pedge();
    nedge(); #1 chk("t2_g2_addr", m_ao, 64'h40);
    pedge();
    nedge(); #1 chk("t2_g3_d", d_rdy, 1);
    chk("t2_g3_i", i_rdy, 0);
    pedge();
    nedge(); i_vld = 1'b0; d_vld = 1'b0;
    #1 chk("t2_g3_addr", m_ao, 64'h80);
    pedge();
    nedge(); m_vi = 1'b1; m_di = 512'h1;
    #1 chk("t2_r1_d", d_rv, 1);
    chk("t2_r1_i", i_rv, 0);
    pedge();
    nedge(); #1 chk("t2_r2_i", i_rv, 1);
    chk("t2_r2_d", d_rv, 0);
    pedge();
    nedge(); #1 chk("t2_r3_d", d_rv, 1);
    chk("t2_r3_i", i_rv, 0);
    pedge();
    nedge(); m_vi = 1'b0;

    // L1D write then orphan response
    d_vld = 1'b1; d_addr = 64'h2000; d_val = pat_5; d_we = 1'b1;
    #1 chk("t3_d_rdy", d_rdy, 1);
    pedge();
    nedge(); d_vld = 1'b0; d_we = 1'b0;
    #1 chk("t3_we", m_we, 1);
    chk("t3_val", m_do, pat_5);
    chk("t3_addr", m_ao, 64'h2000);
    pedge();
    nedge(); m_vi = 1'b1; m_di = 512'h77;
    #1 chk("t3_orph_ro", m_ro, 1);
    chk("t3_orph_i", i_rv, 0);
    chk("t3_orph_d", d_rv, 0);
    pedge();
    nedge(); m_vi = 1'b0;

    // fill FIFO with 4 L1I reads
    i_vld = 1'b1; i_addr = 64'h3000;
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("t4_g%0d", k), i_rdy, 1);
      pedge();
      nedge(); #1 chk($sformatf("t4_h%0d", k), m_vo, 1);
      pedge();
      nedge();
    end
    #1 chk("t4_full_a", i_rdy, 0);
    pedge();
    nedge(); #1 chk("t4_full_b", i_rdy, 0);
    m_vi = 1'b1;
    #1 chk("t4_pop_grant", i_rdy, 1);
    chk("t4_pop_rv", i_rv, 1);
    pedge();
    nedge(); m_vi = 1'b0; i_vld = 1'b0;
    #1 chk("t4_g5_hold", m_vo, 1);
    pedge();

    // drain the four outstanding L1I reads
    nedge(); m_vi = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("t4_drain%0d", k), i_rv, 1);
      pedge();
      nedge();
    end
    m_vi = 1'b0;

    // L1D read response with backpressure
    d_vld = 1'b1; d_addr = 64'h300; d_we = 1'b0;
    #1 chk("t5_d_rdy", d_rdy, 1);
    pedge();
    nedge(); d_vld = 1'b0;
    pedge();
    nedge(); m_vi = 1'b1; d_rr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("t5_bp_ro%0d", k), m_ro, 0);
      chk($sformatf("t5_bp_rv%0d", k), d_rv, 1);
      pedge();
      nedge();
    end
    d_rr = 1'b1;
    #1 chk("t5_rel_ro", m_ro, 1);
    pedge();
    nedge();
    #1 chk("t5_empty_d", d_rv, 0);
    chk("t5_empty_ro", m_ro, 1);
    pedge();
    nedge(); m_vi = 1'b0;

    // reset while in HOLD with 2 outstanding
    i_vld = 1'b1; i_addr = 64'h500;
    pedge();
    pedge();
    nedge(); m_ri = 1'b0;
    pedge();
    nedge(); i_vld = 1'b0;
    #1 chk("t6_hold", m_vo, 1);
    rst_n = 1'b0;
    pedge();
    nedge(); rst_n = 1'b1; m_ri = 1'b1;
    #1 chk("t6_rst_vo", m_vo, 0);
    chk("t6_rst_ao", m_ao, 0);
    chk("t6_rst_ro", m_ro, 0);
    m_vi = 1'b1;
    #1 chk("t6_orph_i", i_rv, 0);
    chk("t6_orph_ro", m_ro, 1);
    pedge();
    nedge(); m_vi = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
